// File: rtl/th_icache_pkg.sv
// th_icache_pkg: shared definitions for the instruction-cache refill controller.
//   - state_e      : controller FSM encoding
//   - pc_tag/pc_set/pc_ofs : field slicers for a {tag, set, offset} word address
//   - line_words   : number of words in a cache line for a given offset width
package th_icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StUpdate,
    StAck
  } state_e;

  // Helpers operate on a zero-extended address of this width; callers truncate.
  localparam int unsigned MaxPcW = 32;

  function automatic int unsigned line_words(input int unsigned ofs_w);
    return 32'd1 << ofs_w;
  endfunction

  function automatic logic [MaxPcW-1:0] pc_tag(input logic [MaxPcW-1:0] pc,
                                               input int unsigned set_w,
                                               input int unsigned ofs_w);
    return pc >> (set_w + ofs_w);
  endfunction

  function automatic logic [MaxPcW-1:0] pc_set(input logic [MaxPcW-1:0] pc,
                                               input int unsigned set_w,
                                               input int unsigned ofs_w);
    return (pc >> ofs_w) & ((32'd1 << set_w) - 32'd1);
  endfunction

  function automatic logic [MaxPcW-1:0] pc_ofs(input logic [MaxPcW-1:0] pc,
                                               input int unsigned ofs_w);
    return pc & ((32'd1 << ofs_w) - 32'd1);
  endfunction

endpackage

// File: rtl/th_icache_lru.sv
// th_icache_lru: one LRU bit per set (1 = way1 is least recently used).
// Ports:
//   clock_i, reset_ni        : clock, async active-low reset (clears all bits)
//   rd_set_i / rd_lru_o      : combinational read port
//   wr_en_i, wr_set_i, wr_lru_i : synchronous write port
module th_icache_lru #(
  parameter int unsigned SET_W = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [SET_W-1:0] rd_set_i,
  output logic             rd_lru_o,
  input  logic             wr_en_i,
  input  logic [SET_W-1:0] wr_set_i,
  input  logic             wr_lru_i
);

  localparam int unsigned Sets = 1 << SET_W;

  logic [Sets-1:0] lru_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lru_q <= '0;
    end else if (wr_en_i) begin
      lru_q[wr_set_i] <= wr_lru_i;
    end
  end

  assign rd_lru_o = lru_q[rd_set_i];

endmodule

// File: rtl/th_icache_ctrl.sv
// th_icache_ctrl: hit/miss decision and line refill for the two-way instruction cache.
// Ports:
//   clock_i, reset_ni                 : clock, async active-low reset
//   enable_i, if_lookup_i, if_pc_i    : lookup request from fetch (held until if_ack_o)
//   if_tag0/1_i, if_vld0/1_i          : stored tags/valids of both ways for the set
//   if_ack_o, if_hit_o                : lookup completion, hit (1) or refilled (0)
//   is_busy_o, is_update_o, is_newtag_o, is_bank_o, is_lru_no : tag update to fetch
//   mem_req_o, mem_addr_o, mem_ack_i, mem_dat_i : refill read from instruction memory
//   cd_we_o, cd_addr_o, cd_dat_o      : cache data RAM write {way, set, offset}
//   st_hits_o, st_miss_o              : saturating statistics counters
// Build option: TH_ICACHE_STATS_EN builds the counters; otherwise both read 0.
// PC_W must equal TAG_W + SET_W + OFS_W.
module th_icache_ctrl
  import th_icache_pkg::*;
#(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned SET_W  = 2,
  parameter int unsigned OFS_W  = 1,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic                     enable_i,
  input  logic                     if_lookup_i,
  input  logic [PC_W-1:0]          if_pc_i,
  input  logic [TAG_W-1:0]         if_tag0_i,
  input  logic [TAG_W-1:0]         if_tag1_i,
  input  logic                     if_vld0_i,
  input  logic                     if_vld1_i,
  output logic                     if_ack_o,
  output logic                     if_hit_o,
  output logic                     is_busy_o,
  output logic                     is_update_o,
  output logic [TAG_W-1:0]         is_newtag_o,
  output logic                     is_bank_o,
  output logic                     is_lru_no,
  output logic                     mem_req_o,
  output logic [PC_W-1:0]          mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_W-1:0]        mem_dat_i,
  output logic                     cd_we_o,
  output logic [1+SET_W+OFS_W-1:0] cd_addr_o,
  output logic [DATA_W-1:0]        cd_dat_o,
  output logic [15:0]              st_hits_o,
  output logic [15:0]              st_miss_o
);

  state_e             state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [OFS_W-1:0]   cnt_q;
  logic               victim_q;

  logic               if_ack_q, if_hit_q, busy_q, is_update_q, is_bank_q, is_lru_q;
  logic [TAG_W-1:0]   is_newtag_q;
  logic               mem_req_q, cd_we_q;
  logic [1+SET_W+OFS_W-1:0] cd_addr_q;
  logic [DATA_W-1:0]  cd_dat_q;

  logic [TAG_W-1:0]   lk_tag;
  logic [SET_W-1:0]   lk_set;
  logic               hit0, hit1, lk_hit, lru_rd, victim, accept, last_word;
  logic               lru_we, lru_wdata;
  logic [SET_W-1:0]   lru_waddr;

  assign lk_tag = TAG_W'(pc_tag(MaxPcW'(if_pc_i), SET_W, OFS_W));
  assign lk_set = SET_W'(pc_set(MaxPcW'(if_pc_i), SET_W, OFS_W));

  assign hit0   = if_vld0_i && (if_tag0_i == lk_tag);
  assign hit1   = if_vld1_i && (if_tag1_i == lk_tag);
  assign lk_hit = hit0 || hit1;
  // Fill an invalid way first; only consult LRU when both ways hold data.
  assign victim = !if_vld0_i ? 1'b0 : (!if_vld1_i ? 1'b1 : lru_rd);

  assign accept    = (state_q == StIdle) && if_lookup_i && enable_i;
  assign last_word = (cnt_q == OFS_W'(line_words(OFS_W) - 1));

  // LRU bit = 1 means way1 is LRU, i.e. way0 was just used (hit0 wins ties).
  assign lru_we    = (accept && lk_hit) || (state_q == StUpdate);
  assign lru_waddr = (state_q == StUpdate) ? set_q : lk_set;
  assign lru_wdata = (state_q == StUpdate) ? ~victim_q : hit0;

  th_icache_lru #(
    .SET_W (SET_W)
  ) u_lru (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .rd_set_i (lk_set),
    .rd_lru_o (lru_rd),
    .wr_en_i  (lru_we),
    .wr_set_i (lru_waddr),
    .wr_lru_i (lru_wdata)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      set_q       <= '0;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      if_hit_q    <= 1'b0;
      busy_q      <= 1'b0;
      is_update_q <= 1'b0;
      is_newtag_q <= '0;
      is_bank_q   <= 1'b0;
      is_lru_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      cd_we_q     <= 1'b0;
      cd_addr_q   <= '0;
      cd_dat_q    <= '0;
    end else begin
      if_ack_q    <= 1'b0;
      is_update_q <= 1'b0;
      cd_we_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tag_q <= lk_tag;
            set_q <= lk_set;
            cnt_q <= '0;
            if (lk_hit) begin
              state_q  <= StAck;
              if_ack_q <= 1'b1;
              if_hit_q <= 1'b1;
            end else begin
              state_q   <= StFill;
              victim_q  <= victim;
              mem_req_q <= 1'b1;
              busy_q    <= 1'b1;
              if_hit_q  <= 1'b0;
            end
          end
        end
        StFill: begin
          if (mem_ack_i) begin
            cd_we_q   <= 1'b1;
            cd_addr_q <= {victim_q, set_q, cnt_q};
            cd_dat_q  <= mem_dat_i;
            cnt_q     <= cnt_q + 1'b1;
            if (last_word) begin
              state_q     <= StUpdate;
              mem_req_q   <= 1'b0;
              is_update_q <= 1'b1;
              is_newtag_q <= tag_q;
              is_bank_q   <= victim_q;
              is_lru_q    <= ~victim_q;
            end
          end
        end
        StUpdate: begin
          state_q  <= StAck;
          busy_q   <= 1'b0;
          if_ack_q <= 1'b1;
        end
        StAck: begin
          state_q  <= StIdle;
          if_hit_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_hit_o    = if_hit_q;
  assign is_busy_o   = busy_q;
  assign is_update_o = is_update_q;
  assign is_newtag_o = is_newtag_q;
  assign is_bank_o   = is_bank_q;
  assign is_lru_no   = is_lru_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = {tag_q, set_q, cnt_q};
  assign cd_we_o     = cd_we_q;
  assign cd_addr_o   = cd_addr_q;
  assign cd_dat_o    = cd_dat_q;

`ifdef TH_ICACHE_STATS_EN
  logic [15:0] st_hits_q, st_miss_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      st_hits_q <= '0;
      st_miss_q <= '0;
    end else begin
      if ((state_q == StAck) && if_hit_q && (st_hits_q != 16'hFFFF)) begin
        st_hits_q <= st_hits_q + 16'd1;
      end
      if ((state_q == StUpdate) && (st_miss_q != 16'hFFFF)) begin
        st_miss_q <= st_miss_q + 16'd1;
      end
    end
  end

  assign st_hits_o = st_hits_q;
  assign st_miss_o = st_miss_q;
`else
  assign st_hits_o = '0;
  assign st_miss_o = '0;
`endif

endmodule
